store_commit_ctrl: RTL and testbench

// Post-commit store buffer and drain scheduler between the memory pipe and the data-cache port.

---
 rtl/store_commit_ctrl_pkg.sv | 25 ++
 rtl/store_commit_ctrl.sv | 141 ++++++++++++++
 tb/tb_store_commit_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_commit_ctrl_pkg.sv
// Shared types for the post-commit store buffer: the buffered store entry and
// the drain-scheduler state encoding.
package store_commit_ctrl_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_REQ  = 2'd1,
    SB_WAIT = 2'd2
  } sb_state_t;

  // Number of stores the commit stage retires this cycle (0, 1 or 2).
  function automatic logic [1:0] commit_count(input logic s1, input logic s2);
    return {1'b0, s1} + {1'b0, s2};
  endfunction

endpackage

// File: rtl/store_commit_ctrl.sv
// Store buffer between the memory pipe and the dcache: speculative enqueue,
// in-order commit marking, flush of the uncommitted tail, single-outstanding drain.
module store_commit_ctrl
  import store_commit_ctrl_pkg::*;
#(
  parameter  int SB_DEPTH = SB_DEPTH_DEFAULT,
  localparam int PTR_W    = $clog2(SB_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_push_valid,
  output logic        o_push_ready,
  input  logic [31:0] i_push_addr,
  input  logic [31:0] i_push_wdata,
  input  logic [3:0]  i_push_wstrb,
  input  logic [1:0]  i_push_size,
  input  logic        i_commit_store1_valid,
  input  logic        i_commit_store2_valid,
  output logic        o_data_req,
  output logic        o_data_wr,
  output logic [1:0]  o_data_size,
  output logic [31:0] o_data_addr,
  output logic [31:0] o_data_wdata,
  output logic [3:0]  o_data_wstrb,
  input  logic        i_data_addr_ok,
  input  logic        i_data_data_ok,
  output logic        o_sb_empty,
  output logic        o_sb_full
);

  localparam int IDX_W = PTR_W - 1;

  sb_entry_t        r_mem [SB_DEPTH];
  sb_entry_t        r_out;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_cmt;
  logic [PTR_W-1:0] r_tail;
  sb_state_t        r_state;

  sb_state_t        w_state_next;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_cmt_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [PTR_W-1:0] w_cmt_cnt;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_load;

  // Occupancy comes from registered pointers only, so push_ready never sees this cycle's pop.
  assign w_full  = (r_tail[PTR_W-1] != r_head[PTR_W-1]) &&
                   (r_tail[IDX_W-1:0] == r_head[IDX_W-1:0]);
  assign w_empty = (r_tail == r_head);
  assign w_push  = i_push_valid && !w_full && !i_flush;

  assign w_cmt_cnt   = {{(PTR_W-2){1'b0}}, commit_count(i_commit_store1_valid, i_commit_store2_valid)};
  assign w_cmt_next  = r_cmt + w_cmt_cnt;
  assign w_head_next = r_head + {{(PTR_W-1){1'b0}}, w_pop};
  assign w_tail_next = i_flush ? w_cmt_next : (r_tail + {{(PTR_W-1){1'b0}}, w_push});

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      SB_IDLE: begin
        if (r_head != r_cmt) begin
          w_state_next = SB_REQ;
          w_load       = 1'b1;
        end
      end
      SB_REQ: begin
        if (i_data_addr_ok) begin
          if (i_data_data_ok) begin
            w_pop        = 1'b1;
            w_state_next = SB_IDLE;
          end else begin
            w_state_next = SB_WAIT;
          end
        end
      end
      SB_WAIT: begin
        if (i_data_data_ok) begin
          w_pop        = 1'b1;
          w_state_next = SB_IDLE;
        end
      end
      default: w_state_next = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_cmt   <= '0;
      r_tail  <= '0;
      r_state <= SB_IDLE;
      r_out   <= '0;
    end else begin
      r_head  <= w_head_next;
      r_cmt   <= w_cmt_next;
      r_tail  <= w_tail_next;
      r_state <= w_state_next;
      if (w_load) begin
        r_out <= r_mem[r_head[IDX_W-1:0]];
      end
    end
  end

  // Entry payload needs no reset: only slots inside [head,tail) are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail[IDX_W-1:0]] <= '{addr:  i_push_addr,
                                    wdata: i_push_wdata,
                                    wstrb: i_push_wstrb,
                                    size:  i_push_size};
    end
  end

  assign o_push_ready = !w_full;
  assign o_sb_full    = w_full;
  assign o_sb_empty   = w_empty;
  assign o_data_req   = (r_state == SB_REQ);
  assign o_data_wr    = (r_state == SB_REQ);
  assign o_data_addr  = r_out.addr;
  assign o_data_wdata = r_out.wdata;
  assign o_data_wstrb = r_out.wstrb;
  assign o_data_size  = r_out.size;

  a_store2_needs_store1: assert property (@(posedge clk) disable iff (!rst_n)
    i_commit_store2_valid |-> i_commit_store1_valid);

  a_commit_within_uncommitted: assert property (@(posedge clk) disable iff (!rst_n)
    w_cmt_cnt <= (r_tail - r_cmt));

  a_data_ok_only_when_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    i_data_data_ok |-> ((r_state == SB_WAIT) || ((r_state == SB_REQ) && i_data_addr_ok)));

endmodule

// File: tb/tb_store_commit_ctrl.sv
// Directed bench for store_commit_ctrl: a queue-level model of the buffer plus
// a small dcache responder, checked every cycle, with literal expectations per scenario.
module tb_store_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, push_valid, c1, c2, addr_ok, data_ok;
  logic [31:0] push_addr, push_wdata;
  logic [3:0]  push_wstrb;
  logic [1:0]  push_size;
  logic        o_push_ready, o_data_req, o_data_wr, o_sb_empty, o_sb_full;
  logic [1:0]  o_data_size;
  logic [31:0] o_data_addr, o_data_wdata;
  logic [3:0]  o_data_wstrb;

  store_commit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush),
    .i_push_valid(push_valid), .o_push_ready(o_push_ready),
    .i_push_addr(push_addr), .i_push_wdata(push_wdata),
    .i_push_wstrb(push_wstrb), .i_push_size(push_size),
    .i_commit_store1_valid(c1), .i_commit_store2_valid(c2),
    .o_data_req(o_data_req), .o_data_wr(o_data_wr), .o_data_size(o_data_size),
    .o_data_addr(o_data_addr), .o_data_wdata(o_data_wdata), .o_data_wstrb(o_data_wstrb),
    .i_data_addr_ok(addr_ok), .i_data_data_ok(data_ok),
    .o_sb_empty(o_sb_empty), .o_sb_full(o_sb_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  size;
  } ent_t;

  // Model: queue of buffered stores (oldest first) and how many of them are committed.
  ent_t        m_q[$];
  int          m_ncmt;
  bit          m_wait;
  logic [31:0] pop_log[$];
  int          req_run, last_req_run;
  int          checks = 0, errors = 0;
  bit          chk_en = 1'b0;

  int addr_delay = 0, data_delay = 0;
  bit same_cycle = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  bit   mdl_pop, mdl_acc;
  int   mdl_cnt;
  ent_t mdl_e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ncmt  = 0;
      m_wait  = 1'b0;
      req_run = 0;
    end else begin
      mdl_pop = 1'b0;
      mdl_acc = push_valid && (m_q.size() < 8) && !flush;
      mdl_cnt = int'(c1) + int'(c2);
      if (o_data_req) begin
        req_run++;
        if (addr_ok) begin
          last_req_run = req_run;
          req_run = 0;
          if (data_ok) mdl_pop = 1'b1;
          else         m_wait  = 1'b1;
        end
      end else if (m_wait && data_ok) begin
        mdl_pop = 1'b1;
        m_wait  = 1'b0;
      end
      if (mdl_pop && m_q.size() > 0) begin
        mdl_e = m_q.pop_front();
        pop_log.push_back(mdl_e.addr);
        if (m_ncmt > 0) m_ncmt--;
      end
      m_ncmt += mdl_cnt;
      if (flush) begin
        while (m_q.size() > m_ncmt) mdl_e = m_q.pop_back();
      end else if (mdl_acc) begin
        m_q.push_back('{push_addr, push_wdata, push_wstrb, push_size});
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("sb_empty", {31'b0, o_sb_empty}, {31'b0, m_q.size() == 0});
      chk("push_ready", {31'b0, o_push_ready}, {31'b0, m_q.size() < 8});
      chk("sb_full", {31'b0, o_sb_full}, {31'b0, m_q.size() >= 8});
      if (m_wait) chk("one_outstanding", {31'b0, o_data_req}, 32'd0);
      if (o_data_req) begin
        chk("req_committed", {31'b0, m_ncmt > 0}, 32'd1);
        chk("data_wr", {31'b0, o_data_wr}, 32'd1);
        if (m_q.size() > 0) begin
          chk("data_addr", o_data_addr, m_q[0].addr);
          chk("data_wdata", o_data_wdata, m_q[0].wdata);
          chk("data_wstrb", {28'b0, o_data_wstrb}, {28'b0, m_q[0].wstrb});
          chk("data_size", {30'b0, o_data_size}, {30'b0, m_q[0].size});
        end
      end
    end
  end

  // Dcache responder: addr_ok after addr_delay waiting cycles, data_ok with it or data_delay later.
  int acnt = 0, dcnt = 0;
  initial begin
    addr_ok = 1'b0;
    data_ok = 1'b0;
    forever begin
      @(negedge clk);
      addr_ok = 1'b0;
      data_ok = 1'b0;
      if (!rst_n) begin
        acnt = 0;
        dcnt = 0;
      end else if (m_wait) begin
        dcnt++;
        if (dcnt > data_delay) begin
          data_ok = 1'b1;
          dcnt = 0;
        end
      end else if (o_data_req) begin
        acnt++;
        if (acnt > addr_delay) begin
          addr_ok = 1'b1;
          data_ok = same_cycle;
          acnt = 0;
          dcnt = 0;
        end
      end
    end
  end

  task automatic clear_inputs();
    flush = 0; push_valid = 0; c1 = 0; c2 = 0;
    push_addr = '0; push_wdata = '0; push_wstrb = '0; push_size = '0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] z);
    push_valid = 1; push_addr = a; push_wdata = d; push_wstrb = s; push_size = z;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic commit(input int n);
    c1 = (n >= 1); c2 = (n == 2);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic wait_pops(input string nm, input int n, input int budget);
    for (int k = 0; k < budget && pop_log.size() < n; k++) @(negedge clk);
    chk(nm, pop_log.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_data_req", {31'b0, o_data_req}, 0);
    chk("rst_data_addr", o_data_addr, 0);
    chk("rst_data_wdata", o_data_wdata, 0);
    chk("rst_data_wstrb", {28'b0, o_data_wstrb}, 0);
    chk("rst_data_size", {30'b0, o_data_size}, 0);
    chk("rst_push_ready", {31'b0, o_push_ready}, 1);
    chk("rst_sb_empty", {31'b0, o_sb_empty}, 1);
    chk("rst_sb_full", {31'b0, o_sb_full}, 0);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);

    // T1: three stores, commit 2 then 1, drained in order through the WAIT path.
    addr_delay = 1; same_cycle = 0; data_delay = 1;
    pop_log.delete();
    push(32'h0000_0100, 32'hA0A0_0001, 4'hF, 2'd2);
    push(32'h0000_0104, 32'hB0B0_0002, 4'h3, 2'd1);
    push(32'h0000_0108, 32'hC0C0_0003, 4'h1, 2'd0);
    chk("t1_no_req_uncommitted", {31'b0, o_data_req}, 0);
    commit(2);
    chk("t1_req_after_cmt_reg", {31'b0, o_data_req}, 0);
    commit(1);
    chk("t1_req_next_cycle", {31'b0, o_data_req}, 1);
    chk("t1_first_addr", o_data_addr, 32'h0000_0100);
    wait_pops("t1_pops", 3, 200);
    chk("t1_order0", pop_log[0], 32'h0000_0100);
    chk("t1_order1", pop_log[1], 32'h0000_0104);
    chk("t1_order2", pop_log[2], 32'h0000_0108);

    // T2: fill to full, 9th push dropped, one drain frees a slot next cycle.
    addr_delay = 0; same_cycle = 1;
    pop_log.delete();
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(4 * i), 32'h2000 + 32'(i), 4'hF, 2'd2);
    chk("t2_full", {31'b0, o_sb_full}, 1);
    chk("t2_not_ready", {31'b0, o_push_ready}, 0);
    push(32'h0000_2FF0, 32'hDEAD_BEEF, 4'hF, 2'd2);
    chk("t2_still_full", {31'b0, o_sb_full}, 1);
    commit(1);
    wait_pops("t2_first_pop", 1, 50);
    chk("t2_slot_free", {31'b0, o_push_ready}, 1);
    push(32'h0000_0220, 32'h2222_2222, 4'hC, 2'd1);
    repeat (4) commit(2);
    wait_pops("t2_pops", 9, 300);
    chk("t2_order0", pop_log[0], 32'h0000_0200);
    chk("t2_order7", pop_log[7], 32'h0000_021C);
    chk("t2_order8", pop_log[8], 32'h0000_0220);

    // T3: 4 pushed, 2 committed, flush with commit1 and a dropped push: exactly 3 drain.
    pop_log.delete();
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(4 * i), 32'h3000 + 32'(i), 4'hF, 2'd2);
    commit(2);
    flush = 1; c1 = 1; push_valid = 1; push_addr = 32'h0000_03F0; push_wdata = 32'h3F3F; push_wstrb = 4'hF;
    @(negedge clk);
    clear_inputs();
    wait_pops("t3_pops", 3, 100);
    repeat (20) @(negedge clk);
    chk("t3_no_fourth", pop_log.size(), 3);
    chk("t3_last", pop_log[2], 32'h0000_0308);
    chk("t3_empty", {31'b0, o_sb_empty}, 1);

    // T4: addr_ok delayed 3 cycles holds the request 4 cycles; immediate accept pops in 1.
    pop_log.delete();
    addr_delay = 3; same_cycle = 1;
    push(32'h0000_0400, 32'h4444_0000, 4'h6, 2'd1);
    commit(1);
    wait_pops("t4_delayed_pop", 1, 50);
    chk("t4_req_cycles_delayed", last_req_run, 4);
    addr_delay = 0;
    push(32'h0000_0404, 32'h4444_0001, 4'h8, 2'd0);
    commit(1);
    wait_pops("t4_fast_pop", 2, 50);
    chk("t4_req_cycles_fast", last_req_run, 1);

    // T5: 20 stores streamed through the pointer wrap, pushing whenever there is room.
    pop_log.delete();
    addr_delay = 0; same_cycle = 0; data_delay = 0;
    begin
      int pushed = 0;
      for (int g = 0; g < 600 && pushed < 20; g++) begin
        c1 = (m_q.size() > m_ncmt);
        if (m_q.size() < 8) begin
          push_valid = 1;
          push_addr  = 32'h500 + 32'(4 * pushed);
          push_wdata = 32'h5000 + 32'(pushed);
          push_wstrb = 4'(pushed);
          push_size  = 2'(pushed % 3);
          pushed++;
        end
        @(negedge clk);
        clear_inputs();
      end
      chk("t5_pushed", pushed, 20);
    end
    for (int g = 0; g < 40 && m_q.size() > m_ncmt; g++) commit(1);
    wait_pops("t5_pops", 20, 400);
    for (int i = 0; i < 20; i++) chk("t5_order", pop_log[i], 32'h500 + 32'(4 * i));
    chk("t5_empty", {31'b0, o_sb_empty}, 1);

    // T6: asynchronous reset while a write is outstanding.
    pop_log.delete();
    data_delay = 40;
    push(32'h0000_0600, 32'h6666_0000, 4'hF, 2'd2);
    push(32'h0000_0604, 32'h6666_0001, 4'hF, 2'd2);
    commit(2);
    for (int k = 0; k < 50 && !m_wait; k++) @(negedge clk);
    chk("t6_in_wait", {31'b0, m_wait}, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_req_cleared", {31'b0, o_data_req}, 0);
    chk("t6_empty", {31'b0, o_sb_empty}, 1);
    chk("t6_ready", {31'b0, o_push_ready}, 1);
    chk("t6_addr_cleared", o_data_addr, 0);
    data_delay = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    pop_log.delete();
    push(32'h0000_0700, 32'h7777_0000, 4'h1, 2'd0);
    commit(1);
    wait_pops("t6_post_reset_pop", 1, 50);
    repeat (10) @(negedge clk);
    chk("t6_only_new", pop_log.size(), 1);
    chk("t6_new_addr", pop_log[0], 32'h0000_0700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
